ack_bus_arbiter_rr: RTL
=======================

Name: ack_bus_arbiter_rr

Overview:
Parametrised, registered successor to the combinational ACK-bus arbiter. It arbitrates NUM_SRC requesters (CTRL/AES/SHA/MEM and future engines) for the shared ACK bus. It issues a one-hot grant that is held for the whole transfer, in fixed-priority or round-robin mode. A watchdog timeout releases a hung grant. Sits between the module ACK interfaces and the bus, and broadcasts the winner ID to all blocks.

Parameters:
NUM_SRC, 4, number of requesters (2..16); index = source ID; ID 0 = MEM, 1 = SHA, 2 = AES, 3 = CTRL.
ID_W, $clog2(NUM_SRC), width of winner_id.
RR_EN, 0, 0 = fixed priority (lowest ID wins); 1 = round-robin.
TIMEOUT, 64, max BUSY cycles before forced release; 0 disables the watchdog.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst_n  input  1  synchronous, active-low reset.
req  input  NUM_SRC  per-source request, level; held until done or abort.
done  input  NUM_SRC  per-source transfer-complete strobe; only the granted bit is honoured.
grant  output  NUM_SRC  registered one-hot ACK-ready to the winner.
winner_id  output  ID_W  ID of the current or last winner.
winner_valid  output  1  high while grant is non-zero.
ack_event  output  1  one-cycle pulse in the first cycle a new grant is visible.
timeout_err  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (rst_n low at a clk edge):
  - grant=0, winner_valid=0, ack_event=0, timeout_err=0.
  - winner_id = all-ones.
  - RR pointer = 0; timeout counter = 0; state = IDLE.
  - Reset mid-transfer drops grant at that edge; no timeout_err is emitted.
- FSM states are IDLE, BUSY, HOLDOFF.
- IDLE:
  - If req != 0, select a winner W. On the next edge: grant=1<<W, winner_id=W, winner_valid=1, ack_event=1, counter=0, state→BUSY.
  - Latency from req sampled to grant visible is exactly 1 cycle.
  - If req == 0, remain in IDLE with all outputs 0; winner_id holds its last value.
- Selection:
  - RR_EN=0: lowest set index.
  - RR_EN=1: first set index searching upward from ptr with wrap-around (ptr, ptr+1, …, NUM_SRC-1, 0, …). On each grant, ptr ← (W+1) mod NUM_SRC.
- BUSY:
  - ack_event is low after its first cycle.
  - Release conditions: done[W]=1, or req[W]=0 (requester abort).
  - On release, at the next edge: grant=0, winner_valid=0, state→HOLDOFF.
  - Otherwise, if TIMEOUT≠0 and counter == TIMEOUT-1, force release the same way and pulse timeout_err for 1 cycle.
  - Otherwise the counter increments; its width is $clog2(TIMEOUT+1) and it never wraps.
  - done/timeout in the same cycle: done wins, no timeout_err.
  - done or req bits of non-winners are ignored while BUSY; new requests wait.
- HOLDOFF:
  - Exactly 1 bus-settle cycle with grant=0, then IDLE.
  - Minimum spacing between consecutive grants is therefore 2 idle cycles of grant (HOLDOFF plus the IDLE evaluation cycle).
- Invariants:
  - grant is always one-hot or zero.
  - winner_valid == |grant.
  - winner_id never changes while winner_valid=1.
  - done asserted in IDLE or HOLDOFF has no effect.
- An out-of-range NUM_SRC is an elaboration error.

Test Plan:
- Reset/basic: rst_n low 2 cycles, then req=4'b0100 → grant=0100 one cycle later; winner_id=2, ack_event pulse 1 cycle; done[2] pulse → grant=0 next cycle, then 1 HOLDOFF cycle.
- Fixed priority (RR_EN=0): req=4'b1111 held, each grant completed by done → winner_id sequence 0,0,0 (ID 0 always wins); CTRL (ID 3) starves.
- Round-robin (RR_EN=1): req=4'b1011 held, same completion → winner_id sequence 0,1,3,0,1,3 with wrap-around; ID 2 is never granted.
- Timeout (TIMEOUT=8): req[1]=1, no done → grant held exactly 8 cycles, timeout_err single pulse on the release edge; done[1] raised on cycle 8 → no timeout_err.
- Abort/ignore: during grant to ID 3, drop req[3] → release next cycle; pulse done[0] while ID 3 is granted → no effect.
- Reset mid-operation: assert rst_n low while BUSY → grant=0, winner_id=all-ones at that edge, no timeout_err; RR pointer back to 0 (req=1111 → first winner 0).

Source files
------------

// File: rtl/ack_bus_arbiter_rr_if.sv
// ACK-bus arbitration bundle: per-source request/done toward the arbiter,
// one-hot grant and winner broadcast back to every block.
interface ack_bus_arbiter_rr_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] done;
    logic [NUM_SRC-1:0] grant;
    logic [ID_W-1:0]    winner_id;
    logic               winner_valid;
    logic               ack_event;
    logic               timeout_err;

    modport master (
        output req, done,
        input  grant, winner_id, winner_valid, ack_event, timeout_err
    );

    modport slave (
        input  req, done,
        output grant, winner_id, winner_valid, ack_event, timeout_err
    );
endinterface

// File: rtl/ack_bus_arbiter_rr.sv
// Registered ACK-bus arbiter: fixed-priority or round-robin one-hot grant held
// for a whole transfer, with a watchdog that forcibly releases a hung owner.
module ack_bus_arbiter_rr #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC),
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    ack_bus_arbiter_rr_if.slave bus
);

    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SRC - 1);

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("ack_bus_arbiter_rr: NUM_SRC must be within 2..16");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SRC-1:0] grant_q;
    logic [ID_W-1:0]    winner_q;
    logic               valid_q;
    logic               ack_q;
    logic               tout_q;

    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    probe;
    logic               sel_hit;
    logic               release_req;
    logic               timeout_hit;

    // Search order starts at ptr in round-robin mode and at 0 in fixed mode.
    always_comb begin
        sel_id  = '0;
        sel_hit = 1'b0;
        probe   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (RR_EN != 0) begin
                probe = ID_W'((int'(ptr) + k) % NUM_SRC);
            end else begin
                probe = ID_W'(k);
            end
            if (!sel_hit && bus.req[probe]) begin
                sel_id  = probe;
                sel_hit = 1'b1;
            end
        end
    end

    assign release_req = bus.done[winner_q] | ~bus.req[winner_q];
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(CNT_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            grant_q  <= '0;
            winner_q <= '1;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            tout_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sel_hit) begin
                        grant_q  <= NUM_SRC'(1) << sel_id;
                        winner_q <= sel_id;
                        valid_q  <= 1'b1;
                        ack_q    <= 1'b1;
                        cnt      <= '0;
                        ptr      <= (sel_id == LAST_ID) ? '0 : sel_id + ID_W'(1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Completion or abort takes precedence over the watchdog.
                    if (release_req) begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        state   <= HOLDOFF;
                    end else if (timeout_hit) begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        tout_q  <= 1'b1;
                        state   <= HOLDOFF;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLDOFF: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.winner_id    = winner_q;
    assign bus.winner_valid = valid_q;
    assign bus.ack_event    = ack_q;
    assign bus.timeout_err  = tout_q;

endmodule
